// File: rtl/main_memory_responder_if.sv
// Request/response bundle between the cache fill path (master) and the
// main-memory responder (slave).
interface main_memory_responder_if #(
  parameter int ADDR_W = 16,
  parameter int DATA_W = 16
);
  logic              enable;
  logic              wr;
  logic [ADDR_W-1:0] addr;
  logic [DATA_W-1:0] data_in;
  logic [DATA_W-1:0] data_out;
  logic              data_valid;
  logic [3:0]        inflight;

  modport master (
    output enable, wr, addr, data_in,
    input  data_out, data_valid, inflight
  );

  modport slave (
    input  enable, wr, addr, data_in,
    output data_out, data_valid, inflight
  );
endinterface

// File: rtl/main_memory_responder.sv
// Synchronous word-addressed backing store with a fixed-latency read pipeline.
// Read data is snapshotted when the request is accepted, so later writes never disturb it.
module main_memory_responder #(
  parameter int ADDR_W  = 16,
  parameter int DATA_W  = 16,
  parameter int INDEX_W = 10,
  parameter int LATENCY = 4
) (
  input logic                    clk,
  input logic                    rst_n,
  main_memory_responder_if.slave bus
);
  localparam int DEPTH = 1 << INDEX_W;

  logic [DATA_W-1:0]  mem_r [DEPTH];
  logic [LATENCY-1:0] pipe_valid_r;
  logic [DATA_W-1:0]  pipe_data_r [LATENCY];
  logic [3:0]         inflight_r;
  logic [3:0]         inflight_next_s;
  logic [INDEX_W-1:0] index_s;
  logic               rd_accept_s;
  logic               wr_accept_s;
  logic               last_valid_s;
  logic               unused_addr_s;

  // Decode the request; addr[0] and bits above the index alias away.
  always_comb begin
    index_s       = bus.addr[INDEX_W:1];
    rd_accept_s   = bus.enable & ~bus.wr;
    wr_accept_s   = bus.enable & bus.wr;
    last_valid_s  = pipe_valid_r[LATENCY-1];
    unused_addr_s = ^{bus.addr[ADDR_W-1:INDEX_W+1], bus.addr[0]};
  end

  // Storage array has no reset: contents survive rst_n and are undefined at power-up.
  always_ff @(posedge clk) begin
    if (wr_accept_s) begin
      mem_r[index_s] <= bus.data_in;
    end
  end

  // Read pipeline: stage 0 captures the word at issue, then every stage shifts each cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pipe_valid_r <= {LATENCY{1'b0}};
      for (int i = 0; i < LATENCY; i++) begin
        pipe_data_r[i] <= {DATA_W{1'b0}};
      end
      inflight_r <= 4'd0;
    end else begin
      pipe_valid_r[0] <= rd_accept_s;
      pipe_data_r[0]  <= rd_accept_s ? mem_r[index_s] : {DATA_W{1'b0}};
      for (int i = 1; i < LATENCY; i++) begin
        pipe_valid_r[i] <= pipe_valid_r[i-1];
        pipe_data_r[i]  <= pipe_data_r[i-1];
      end
      inflight_r <= inflight_next_s;
    end
  end

  // A read accepted and a response leaving in the same cycle cancel out.
  always_comb begin
    inflight_next_s = inflight_r;
    if (rd_accept_s && !last_valid_s) begin
      inflight_next_s = inflight_r + 4'd1;
    end else if (!rd_accept_s && last_valid_s) begin
      inflight_next_s = inflight_r - 4'd1;
    end else begin
      inflight_next_s = inflight_r;
    end
  end

  always_comb begin
    bus.data_valid = last_valid_s;
    bus.data_out   = last_valid_s ? pipe_data_r[LATENCY-1] : {DATA_W{1'b0}};
    bus.inflight   = inflight_r;
  end
endmodule

// File: tb/tb_main_memory_responder.sv
// Scoreboard bench: one stimulus stream drives a LATENCY=4 and a LATENCY=1 responder
// side by side; a reference memory produces expected words, a monitor checks every cycle.
module tb_main_memory_responder;
  logic        clk = 1'b0;
  logic        rst_n;
  logic        en_v = 1'b0;
  logic        wr_v = 1'b0;
  logic [15:0] addr_v = 16'd0;
  logic [15:0] din_v = 16'd0;

  always #5 clk = ~clk;

  main_memory_responder_if bus_a ();
  main_memory_responder_if bus_b ();

  assign bus_a.enable  = en_v;
  assign bus_a.wr      = wr_v;
  assign bus_a.addr    = addr_v;
  assign bus_a.data_in = din_v;
  assign bus_b.enable  = en_v;
  assign bus_b.wr      = wr_v;
  assign bus_b.addr    = addr_v;
  assign bus_b.data_in = din_v;

  main_memory_responder #(.LATENCY(4)) dut_a (.clk(clk), .rst_n(rst_n), .bus(bus_a.slave));
  main_memory_responder #(.LATENCY(1)) dut_b (.clk(clk), .rst_n(rst_n), .bus(bus_b.slave));

  typedef struct {
    int          issue;
    logic [15:0] data;
  } exp_t;

  exp_t        sb_a [$];
  exp_t        sb_b [$];
  logic [15:0] ref_mem [1024];
  int          cyc = 0;
  int          n_cmp = 0;
  int          n_bad = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Outstanding reads are those sampled by an earlier edge and not yet popped.
  task automatic mon_port(input int sel, input int lat, input logic dv,
                          input logic [15:0] dout, input logic [3:0] infl);
    exp_t  q [$];
    int    pend;
    string nm;
    pend = 0;
    nm   = (sel == 0) ? "L4" : "L1";
    if (sel == 0) q = sb_a; else q = sb_b;
    foreach (q[i]) if (q[i].issue < cyc) pend++;
    check({nm, " inflight"}, 32'(infl), 32'(pend));
    while (q.size() > 0 && q[0].issue + lat < cyc) begin
      n_cmp++;
      n_bad++;
      $display("FAIL %s missing_response: got no strobe, expected data %h in cycle %0d",
               nm, q[0].data, q[0].issue + lat);
      void'(q.pop_front());
    end
    if (q.size() > 0 && q[0].issue + lat == cyc) begin
      check({nm, " data_valid"}, 32'(dv), 32'd1);
      check({nm, " data_out"}, 32'(dout), 32'(q[0].data));
      void'(q.pop_front());
    end else begin
      check({nm, " idle_valid"}, 32'(dv), 32'd0);
      check({nm, " idle_data_zero"}, 32'(dout), 32'd0);
    end
    if (sel == 0) sb_a = q; else sb_b = q;
  endtask

  always @(negedge clk) begin
    mon_port(0, 4, bus_a.data_valid, bus_a.data_out, bus_a.inflight);
    mon_port(1, 1, bus_b.data_valid, bus_b.data_out, bus_b.inflight);
  end

  // One request per cycle; the reference memory is updated with plain word-index arithmetic.
  task automatic req(input logic e, input logic w, input logic [15:0] a, input logic [15:0] d);
    exp_t x;
    int   idx;
    @(posedge clk);
    #1;
    en_v   = e;
    wr_v   = w;
    addr_v = a;
    din_v  = d;
    idx    = (int'(a) / 2) % 1024;
    if (e && !w) begin
      x.issue = cyc;
      x.data  = ref_mem[idx];
      sb_a.push_back(x);
      sb_b.push_back(x);
    end
    if (e && w) ref_mem[idx] = d;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) req(1'b0, 1'b0, 16'd0, 16'd0);
  endtask

  task automatic mid_reset();
    @(posedge clk);
    #3;
    rst_n = 1'b0;
    en_v  = 1'b0;
    sb_a.delete();
    sb_b.delete();
    #1;
    check("rst_async_valid_a", 32'(bus_a.data_valid), 32'd0);
    check("rst_async_inflight_a", 32'(bus_a.inflight), 32'd0);
    check("rst_async_valid_b", 32'(bus_b.data_valid), 32'd0);
    check("rst_async_inflight_b", 32'(bus_b.inflight), 32'd0);
    @(negedge clk);
    #2;
    rst_n = 1'b1;
  endtask

  initial begin
    rst_n = 1'b1;
    #2 rst_n = 1'b0;
    #10;
    check("reset_valid_a", 32'(bus_a.data_valid), 32'd0);
    check("reset_data_a", 32'(bus_a.data_out), 32'd0);
    check("reset_inflight_a", 32'(bus_a.inflight), 32'd0);
    check("reset_inflight_b", 32'(bus_b.inflight), 32'd0);
    #9 rst_n = 1'b1;

    // Give every word a known value so random reads are fully checkable.
    for (int i = 0; i < 1024; i++) req(1'b1, 1'b1, 16'(i * 2), 16'($urandom));

    // Single write then read after two idle cycles.
    req(1'b1, 1'b1, 16'h0010, 16'hBEEF);
    idle(2);
    req(1'b0 | 1'b1, 1'b0, 16'h0010, 16'd0);
    idle(6);

    // Cache block fill: eight back-to-back reads.
    for (int i = 0; i < 8; i++) req(1'b1, 1'b1, 16'h0020 + 16'(2 * i), 16'h1000 + 16'(i));
    for (int i = 0; i < 8; i++) req(1'b1, 1'b0, 16'h0020 + 16'(2 * i), 16'd0);
    idle(6);

    // Read-then-write hazard and write-then-read visibility.
    req(1'b1, 1'b1, 16'h0040, 16'hAAAA);
    idle(1);
    req(1'b1, 1'b0, 16'h0040, 16'd0);
    req(1'b1, 1'b1, 16'h0040, 16'h5555);
    req(1'b1, 1'b0, 16'h0040, 16'd0);
    idle(6);

    // Aliasing through the upper address bits and addr[0].
    req(1'b1, 1'b1, 16'h0800, 16'h1234);
    req(1'b1, 1'b0, 16'h0000, 16'd0);
    req(1'b1, 1'b0, 16'h0801, 16'd0);
    idle(6);

    // Reset with reads in flight, then the array must still hold its data.
    req(1'b1, 1'b1, 16'h0100, 16'h7777);
    for (int i = 0; i < 3; i++) req(1'b1, 1'b0, 16'h0100 + 16'(2 * i), 16'd0);
    mid_reset();
    idle(8);
    req(1'b1, 1'b0, 16'h0100, 16'd0);
    idle(6);

    // Read / idle / write / read interleave to distinct addresses.
    for (int i = 0; i < 6; i++) begin
      req(1'b1, 1'b0, 16'h0200 + 16'(8 * i), 16'd0);
      req(1'b0, 1'b0, 16'd0, 16'd0);
      req(1'b1, 1'b1, 16'h0202 + 16'(8 * i), 16'($urandom));
      req(1'b1, 1'b0, 16'h0204 + 16'(8 * i), 16'd0);
    end
    idle(6);

    // Random traffic, full 16-bit addresses to exercise aliasing.
    for (int i = 0; i < 400; i++) begin
      req($urandom_range(0, 3) != 0, 1'($urandom_range(0, 1)), 16'($urandom), 16'($urandom));
    end
    idle(1);

    for (int i = 0; i < 20 && (sb_a.size() > 0 || sb_b.size() > 0); i++) @(negedge clk);
    #1;
    if (sb_a.size() > 0 || sb_b.size() > 0) begin
      n_cmp++;
      n_bad++;
      $display("FAIL drain: got %0d/%0d responses still pending, expected 0/0",
               sb_a.size(), sb_b.size());
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
